// File: rtl/mbgd_dot_ctrl.sv
// Mini-batch dot-product controller: streams row pairs into an external
// multiplier array. It accumulates the registered lane products and
// returns one accumulated result per job.
//
// Handshakes (both sides use strict valid/ready semantics):
// - A transfer happens on a rising clk edge where valid && ready.
// - A producer holds valid and its data stable until the transfer happens.
// - ready never depends on valid.
// - Input side: in_valid/in_ready carry in_a/in_b.
// - Output side: out_valid/out_ready carry result.
module mbgd_dot_ctrl #(
  parameter int N     = 8,
  parameter int N_bit = 3,
  parameter int DW    = 8,
  parameter int LEN_W = 8,
  parameter int ACC_W = 2*DW + N_bit + LEN_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_W-1:0]    num_rows,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW*N-1:0]     in_a,
  input  logic [DW*N-1:0]     in_b,
  output logic                mul_en,
  output logic [DW*N-1:0]     mul_inp1,
  output logic [DW*N-1:0]     mul_inp2,
  input  logic [2*DW*N-1:0]   dot_products,
  output logic                busy,
  output logic [ACC_W-1:0]    result,
  output logic                out_valid,
  input  logic                out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // state is kept as a named enum so checkers can bind to it directly
  state_t             state;
  state_t             state_next;
  logic [LEN_W-1:0]   rows_left;
  logic               prod_vld;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   lane_sum;
  logic               accept;
  logic               job_start;

  assign accept    = in_valid && in_ready;
  assign job_start = (state == IDLE) && start;

  // Operands go straight to the array; the array registers its own products.
  assign mul_en    = accept;
  assign mul_inp1  = in_a;
  assign mul_inp2  = in_b;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = acc;

  // Ready only while rows remain to be fed.
  always_comb begin
    in_ready = 1'b0;
    if (state == FEED && rows_left != '0) in_ready = 1'b1;
  end

  // Zero-extended sum of all lane products; ACC_W leaves headroom, so there is no wrap.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < N; i++) begin
      lane_sum = lane_sum + ACC_W'(dot_products[i*2*DW +: 2*DW]);
    end
  end

  // Next-state logic; start outside IDLE is simply not looked at.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (num_rows == '0) ? DONE : FEED;
      end
      FEED: begin
        if (accept && rows_left == LEN_W'(1)) state_next = DRAIN;
      end
      DRAIN: begin
        // one cycle for the final registered product to land in acc
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Row countdown, loaded when a job is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rows_left <= '0;
    else if (job_start) rows_left <= num_rows;
    else if (accept)    rows_left <= rows_left - LEN_W'(1);
  end

  // Product-valid tracks the array's one-cycle latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prod_vld <= 1'b0;
    else       prod_vld <= mul_en;
  end

  // Accumulator: cleared on job start and advanced only by landed products.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          acc <= '0;
    else if (job_start) acc <= '0;
    else if (prod_vld)  acc <= acc + lane_sum;
  end

endmodule

// File: tb/tb_mbgd_dot_ctrl.sv
// Directed bench for mbgd_dot_ctrl with a behavioural multiplier array.
module tb_mbgd_dot_ctrl;

  localparam int N     = 8;
  localparam int DW    = 8;
  localparam int LEN_W = 8;
  localparam int ACC_W = 2*DW + 3 + LEN_W;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [LEN_W-1:0]   num_rows;
  logic               in_valid;
  logic               in_ready;
  logic [DW*N-1:0]    in_a;
  logic [DW*N-1:0]    in_b;
  logic               mul_en;
  logic [DW*N-1:0]    mul_inp1;
  logic [DW*N-1:0]    mul_inp2;
  logic [2*DW*N-1:0]  dot_products;
  logic               busy;
  logic [ACC_W-1:0]   result;
  logic               out_valid;
  logic               out_ready;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  mbgd_dot_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_rows     (num_rows),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .mul_en       (mul_en),
    .mul_inp1     (mul_inp1),
    .mul_inp2     (mul_inp2),
    .dot_products (dot_products),
    .busy         (busy),
    .result       (result),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Multiplier array model: registers lane products one cycle after mul_en.
  always @(posedge clk) begin
    if (mul_en) begin
      for (int i = 0; i < N; i++) begin
        dot_products[i*2*DW +: 2*DW] <= 16'(in_a[i*DW +: DW]) * 16'(in_b[i*DW +: DW]);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW*N-1:0] rep(input logic [DW-1:0] v);
    logic [DW*N-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_mul_en"},    mul_en,    0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_result"},    result,    0);
  endtask

  // Callers sit at a negedge; leaves the bench at the following negedge.
  task automatic start_job(input logic [LEN_W-1:0] n, input logic [63:0] exp);
    exp_q.push_back(exp);
    start = 1'b1;
    num_rows = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one row pair and waits (bounded) for its handshake.
  task automatic send_row(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    int t = 0;
    in_a = rep(av);
    in_b = rep(bv);
    in_valid = 1'b1;
    #1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("row_ready", in_ready, 1);
    check("row_mul_en", mul_en, 1);
    check("row_mul_inp1", mul_inp1, rep(av));
    check("row_mul_inp2", mul_inp2, rep(bv));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic bubble(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      #1;
      check("bubble_mul_en", mul_en, 0);
      check("bubble_ready", in_ready, 1);
      @(negedge clk);
    end
  endtask

  // Called at the negedge right after the last handshake (DRAIN).
  task automatic finish_job(input int hold);
    logic [63:0] exp;
    exp = exp_q.pop_front();
    check("drain_ready", in_ready, 0);
    check("drain_valid", out_valid, 0);
    check("drain_busy", busy, 1);
    out_ready = (hold == 0);
    @(negedge clk);
    check("done_valid", out_valid, 1);
    check("done_result", result, exp);
    for (int i = 0; i < hold; i++) begin
      start = 1'b1;
      num_rows = 8'd3;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", result, exp);
      check("hold_ready", in_ready, 0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_rows = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("por");
    reset = 1'b0;
    @(negedge clk);

    // single row: lanes 1x2 -> 8*2 = 16
    start_job(8'd1, 64'd16);
    check("s1_busy", busy, 1);
    send_row(8'd1, 8'd2);
    finish_job(0);

    // three rows with bubbles: 8 + 48 + 160 = 216
    start_job(8'd3, 64'd216);
    send_row(8'd1, 8'd1);
    bubble(2);
    send_row(8'd2, 8'd3);
    bubble(2);
    send_row(8'd4, 8'd5);
    finish_job(0);

    // zero rows: DONE right after start, no feeding
    out_ready = 1'b0;
    start = 1'b1;
    num_rows = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("z_ready", in_ready, 0);
    check("z_valid", out_valid, 1);
    check("z_result", result, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("z_idle", busy, 0);

    // max-value stress: 255*255*8*255
    start_job(8'd255, 64'd132651000);
    for (int r = 0; r < 255; r++) send_row(8'd255, 8'd255);
    finish_job(0);

    // backpressure with start pulsed in DONE
    start_job(8'd1, 64'd16);
    send_row(8'd1, 8'd2);
    finish_job(5);
    @(negedge clk);
    check("bp_no_queue", busy, 0);

    // reset mid-FEED after 2 of 4 rows (7x7 -> 392 per row)
    start_job(8'd4, 64'd0);
    void'(exp_q.pop_back());
    send_row(8'd7, 8'd7);
    send_row(8'd7, 8'd7);
    check("mid_result", result, 64'd392);
    in_valid = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("mid_rst");
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_job(8'd1, 64'd72);
    send_row(8'd3, 8'd3);
    finish_job(0);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mbgd_dot_ctrl.md
MBGD_DOT_CTRL -- requirements
Module: mbgd_dot_ctrl

Interface
REQ-001 Parameters SHALL be:
- N, default 8: elements per row.
- N_bit, default 3: log2(N).
- DW, default 8: bits per unsigned element.
- LEN_W, default 8: row-count width.
- ACC_W = 2*DW + N_bit + LEN_W: accumulator width.

REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin job; sampled only in IDLE.
- num_rows  in  LEN_W  rows in job; latched on accepted start.
- in_valid  in  1  row pair present.
- in_ready  out  1  row pair accepted when in_valid && in_ready.
- in_a  in  DW*N  row operand A.
- in_b  in  DW*N  row operand B.
- mul_en  out  1  enable to the dot-product multiplier array.
- mul_inp1  out  DW*N  operand to the array; equals in_a.
- mul_inp2  out  DW*N  operand to the array; equals in_b.
- dot_products  in  2*DW*N  registered lane products from the array, one cycle after mul_en.
- busy  out  1  state != IDLE.
- result  out  ACC_W  accumulated dot product.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.

Function
REQ-003 States SHALL be IDLE, FEED, DRAIN and DONE, using a registered state and a combinational next-state.

REQ-004 IDLE with start=1 and num_rows>0 SHALL do all of the following at the edge:
- Clear acc.
- Load rows_left=num_rows.
- Go to FEED.

REQ-005 IDLE with start=1 and num_rows=0 SHALL clear acc and go directly to DONE.

REQ-006 in_ready SHALL be 1 only in FEED with rows_left>0; it SHALL be 0 in every other state.

REQ-007 mul_en SHALL equal in_valid && in_ready, combinationally, and mul_inp1/mul_inp2 SHALL be direct pass-through of in_a/in_b.

REQ-008 Each accepted row SHALL decrement rows_left.
- When the accepted row is the last (rows_left=1), FEED SHALL go to DRAIN at that edge.

REQ-009 prod_vld SHALL be a register holding mul_en delayed by one cycle.

REQ-010 When prod_vld=1, acc SHALL add the unsigned sum of the N DW*2-bit lanes of dot_products at the clock edge.
- The lane sum SHALL be zero-extended to ACC_W.
- The sum SHALL NOT truncate.

REQ-011 DRAIN SHALL last exactly one cycle, to absorb the final prod_vld, and then go to DONE.
- out_valid SHALL therefore rise 2 cycles after the last row handshake.

REQ-012 out_valid SHALL be 1 only in DONE, and result SHALL equal acc and be held stable while out_valid=1.

REQ-013 DONE with out_ready=1 SHALL go to IDLE at that edge; with out_ready=0, DONE SHALL hold indefinitely.

REQ-014 start asserted in FEED, DRAIN or DONE SHALL be ignored and SHALL NOT be queued.

REQ-015 Input bubbles (in_valid=0 in FEED) SHALL stall without state change, and acc SHALL update only on prod_vld.

REQ-016 Arithmetic SHALL be unsigned. With ACC_W as defined, the worst case SHALL NOT overflow: (2^DW-1)^2 * N * (2^LEN_W-1).

Reset
REQ-017 reset=1 SHALL asynchronously force all of the following, including when reset occurs mid-job:
- state=IDLE, rows_left=0, prod_vld=0, acc=0.
- in_ready=0, mul_en=0, busy=0, out_valid=0, result=0.
- The job in progress SHALL be discarded.

REQ-018 After reset deassertion, the first accepted start SHALL behave identically to a start after power-up.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Single row: num_rows=1, all bytes of in_a=1, all bytes of in_b=2, out_ready=1 -> out_valid 2 cycles after the handshake, result=16, then IDLE.
- Three rows with bubbles: num_rows=3, rows of lane values 1x1, 2x3, 4x5, and in_valid low 2 cycles between rows -> result=8+48+160=216; in_ready drops after the third handshake.
- Zero rows: num_rows=0 -> DONE the cycle after start, result=0, in_ready never 1.
- Max-value stress: num_rows=255, all bytes 255 -> result=255*255*8*255=132651000 with no wrap.
- Backpressure: out_ready=0 for 5 cycles in DONE, with start pulsed -> result stable and start ignored; IDLE one cycle after out_ready=1.
- Reset mid-FEED after 2 of 4 rows -> all outputs 0 immediately. A new job with num_rows=1, lanes 3x3 -> result=72, with no residue from the aborted job.
